// File: rtl/cc_truth_table_driver.sv
// Drives a two-input gate through all four {a,b} vectors, samples z after a settle
// window and reports pass/fail, error count and per-vector failure mask.
module cc_truth_table_driver #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] EXPECT        = 4'b1000
) (
  input  logic       CC_TruthTableDriver_CLOCK_50,
  input  logic       CC_TruthTableDriver_RESET_InLow,
  input  logic       CC_TruthTableDriver_start_In,
  input  logic       CC_TruthTableDriver_z_In,
  output logic       CC_TruthTableDriver_a_Out,
  output logic       CC_TruthTableDriver_b_Out,
  output logic       CC_TruthTableDriver_busy_Out,
  output logic       CC_TruthTableDriver_done_Out,
  output logic       CC_TruthTableDriver_pass_Out,
  output logic [2:0] CC_TruthTableDriver_errCount_Out,
  output logic [3:0] CC_TruthTableDriver_failMask_Out
);

  // state  | meaning
  // IDLE   | waiting for start, results of last run held
  // SETTLE | current vector applied, counting down settle time
  // SAMPLE | z sampled on the edge leaving this state
  // FINISH | done pulse cycle, start ignored
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;

  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] mask_q, mask_d;

  logic       mismatch;
  logic [2:0] err_next;
  logic [1:0] idx_inc;

  assign mismatch = (CC_TruthTableDriver_z_In != EXPECT[idx_q]);
  assign err_next = err_q + {2'b00, mismatch};
  assign idx_inc  = idx_q + 2'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (CC_TruthTableDriver_start_In) begin
          state_d = SETTLE;
          idx_d   = 2'd0;
          cnt_d   = CNT_RELOAD;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = 3'd0;
          mask_d  = 4'd0;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_d = SAMPLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      SAMPLE: begin
        err_d = err_next;
        if (mismatch) mask_d[idx_q] = 1'b1;
        if (idx_q != 2'd3) begin
          state_d = SETTLE;
          idx_d   = idx_inc;
          cnt_d   = CNT_RELOAD;
          a_d     = idx_inc[1];
          b_d     = idx_inc[0];
        end else begin
          // final verdict includes the sample taken on this same edge
          state_d = FINISH;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next == 3'd0);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CC_TruthTableDriver_CLOCK_50 or negedge CC_TruthTableDriver_RESET_InLow) begin
    if (!CC_TruthTableDriver_RESET_InLow) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      mask_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
    end
  end

  assign CC_TruthTableDriver_a_Out        = a_q;
  assign CC_TruthTableDriver_b_Out        = b_q;
  assign CC_TruthTableDriver_busy_Out     = busy_q;
  assign CC_TruthTableDriver_done_Out     = done_q;
  assign CC_TruthTableDriver_pass_Out     = pass_q;
  assign CC_TruthTableDriver_errCount_Out = err_q;
  assign CC_TruthTableDriver_failMask_Out = mask_q;

endmodule

// File: tb/tb_cc_truth_table_driver.sv
// Bench for cc_truth_table_driver: the gate under test is a programmable truth table,
// expected timing and results come from the vector schedule and XOR of truth tables.
module tb_cc_truth_table_driver;

  localparam int         S     = 2;
  localparam logic [3:0] EXP   = 4'b1000;
  localparam int         P     = S + 1;
  localparam int         DONE_E = 4 * P;
  localparam int         END_E  = 4 * P + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] gate_tt = 4'b1000;
  logic       z;
  logic       a, b, busy, done, pass;
  logic [2:0] err;
  logic [3:0] mask;

  int checks = 0;
  int failures = 0;

  assign z = gate_tt[{a, b}];

  always #5 clk = ~clk;

  cc_truth_table_driver #(.SETTLE_CYCLES(S), .EXPECT(EXP)) dut (
    .CC_TruthTableDriver_CLOCK_50       (clk),
    .CC_TruthTableDriver_RESET_InLow    (rst_n),
    .CC_TruthTableDriver_start_In       (start),
    .CC_TruthTableDriver_z_In           (z),
    .CC_TruthTableDriver_a_Out          (a),
    .CC_TruthTableDriver_b_Out          (b),
    .CC_TruthTableDriver_busy_Out       (busy),
    .CC_TruthTableDriver_done_Out       (done),
    .CC_TruthTableDriver_pass_Out       (pass),
    .CC_TruthTableDriver_errCount_Out   (err),
    .CC_TruthTableDriver_failMask_Out   (mask)
  );

  function automatic int popc(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ea, input logic eb, input logic ebusy,
                         input logic edone, input logic epass, input int eerr, input logic [3:0] emask);
    chk({tag, ".a"},    8'(a),    8'(ea));
    chk({tag, ".b"},    8'(b),    8'(eb));
    chk({tag, ".busy"}, 8'(busy), 8'(ebusy));
    chk({tag, ".done"}, 8'(done), 8'(edone));
    chk({tag, ".pass"}, 8'(pass), 8'(epass));
    chk({tag, ".err"},  8'(err),  8'(eerr));
    chk({tag, ".mask"}, 8'(mask), 8'(emask));
  endtask

  // mode 0: single start pulse; 1: start held through the run; 2: extra pulses at edges 3 and DONE_E
  task automatic run(input logic [3:0] tt, input int mode, input string tag);
    logic [3:0] mm;
    logic [3:0] low;
    int k;
    mm = tt ^ EXP;
    gate_tt = tt;
    start = 1'b1;
    for (int t = 0; t <= END_E; t++) begin
      tick();
      if (t < DONE_E) begin
        k = t / P;
        low = 4'((1 << k) - 1);
        chk_all($sformatf("%s.e%0d", tag, t), k[1], k[0], 1'b1, 1'b0, 1'b0,
                popc(mm & low), mm & low);
      end else if (t == DONE_E) begin
        chk_all($sformatf("%s.done_e%0d", tag, t), 1'b0, 1'b0, 1'b0, 1'b1,
                (mm == 4'd0), popc(mm), mm);
      end else begin
        chk_all($sformatf("%s.after_e%0d", tag, t), 1'b0, 1'b0, 1'b0, 1'b0,
                (mm == 4'd0), popc(mm), mm);
      end
      case (mode)
        1:       start = (t + 1 <= END_E);
        2:       start = (t + 1 == 3) || (t + 1 == DONE_E);
        default: start = 1'b0;
      endcase
    end
  endtask

  task automatic idle_gap(input int n, input logic [3:0] tt, input string tag);
    logic [3:0] mm;
    mm = tt ^ EXP;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      chk_all($sformatf("%s.gap%0d", tag, i), 1'b0, 1'b0, 1'b0, 1'b0, (mm == 4'd0), popc(mm), mm);
    end
  endtask

  initial begin
    logic [3:0] tt;
    int mode;

    // reset with random inputs
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom);
      gate_tt = 4'($urandom);
      #1;
      chk_all($sformatf("rst%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4'd0);
      tick();
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_all($sformatf("post_rst%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4'd0);
    end

    run(4'b1000, 0, "and");
    idle_gap(2, 4'b1000, "and");
    run(4'b0000, 0, "stuck0");
    idle_gap(2, 4'b0000, "stuck0");
    run(4'b1110, 0, "or");
    idle_gap(1, 4'b1110, "or");
    run(4'b1000, 0, "and2");
    idle_gap(1, 4'b1000, "and2");

    run(4'b1000, 2, "repulse");
    idle_gap(1, 4'b1000, "repulse");
    run(4'b1000, 1, "hold");
    run(4'b0110, 0, "b2b");
    idle_gap(2, 4'b0110, "b2b");

    // reset during SETTLE of vector 2
    gate_tt = 4'b1000;
    start = 1'b1;
    for (int t = 0; t <= 7; t++) begin
      tick();
      start = 1'b0;
    end
    chk_all("midrun.e7", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 4'd0);
    rst_n = 1'b0;
    #1;
    chk_all("midrun.rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("midrun.hold%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_all($sformatf("midrun.idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4'd0);
    end
    run(4'b1000, 0, "midrun.rerun");
    idle_gap(1, 4'b1000, "midrun.rerun");

    for (int r = 0; r < 10; r++) begin
      tt = 4'($urandom);
      mode = int'($urandom_range(0, 2));
      run(tt, mode, $sformatf("rnd%0d", r));
      idle_gap(int'($urandom_range(0, 3)), tt, $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
